// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, tick-sampled debounce
// with hysteresis, rise/fall pulses and per-channel long-press detection.
// A shared divider produces a one-clk sample tick used as a clock enable.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat pulses on o_rpt
// while a press is held past the long-press point). Without it o_rpt is 0.
module btn_debounce_multi #(
  parameter int N_CH         = 4,
  parameter int F_COUNT      = 1000,
  parameter int DB_DEPTH     = 8,
  parameter int LONG_TICKS   = 50000,
  parameter int REPEAT_TICKS = 10000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_rpt
);

  localparam int DIV_W = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HELD
  } state_t;

  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [N_CH-1:0]     sync_meta;
  logic [N_CH-1:0]     sync_q;
  logic [DB_DEPTH-1:0] shreg [N_CH];
  logic [N_CH-1:0]     level_d;
  state_t              state_q [N_CH];
  state_t              state_d [N_CH];
  logic [31:0]         hold_q  [N_CH];
  logic [31:0]         hold_d  [N_CH];
  logic [N_CH-1:0]     long_d;
`ifdef BTN_AUTOREPEAT_EN
  logic [N_CH-1:0]     rpt_d;
`endif

  // Shared sample divider: counts 0..F_COUNT-1, tick on the last count.
  // With F_COUNT == 1 the counter stays at 0 and tick is constantly high.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_W'(F_COUNT - 1));

  // Two-flop synchroniser for the raw asynchronous buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= i_btn;
      sync_q    <= sync_meta;
    end
  end

  // Per-channel sample history, advanced only on the sample tick.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the history array is cleared on reset on purpose: a stale
    // all-ones history would re-assert the level right after reset.
    if (rst) begin
      for (int i = 0; i < N_CH; i++) shreg[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_CH; i++) shreg[i] <= {shreg[i][DB_DEPTH-2:0], sync_q[i]};
    end
  end

  // Hysteresis: set on all-ones history, clear on all-zeros, otherwise hold.
  always_comb begin
    // NOTE: level_d gets a full default before any condition, so no latch
    // can be inferred for channels whose history is mixed.
    level_d = o_level;
    for (int i = 0; i < N_CH; i++) begin
      if (&shreg[i])       level_d[i] = 1'b1;
      else if (~|shreg[i]) level_d[i] = 1'b0;
    end
  end

  // Registered level with edge pulses aligned to the first cycle of the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_level <= '0;
      o_rise  <= '0;
      o_fall  <= '0;
    end else begin
      o_level <= level_d;
      o_rise  <= level_d & ~o_level;
      o_fall  <= ~level_d & o_level;
    end
  end

  // Long-press FSM next-state: release wins over long/repeat in the same cycle.
  always_comb begin
    long_d = '0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_d  = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      if (o_fall[i]) begin
        state_d[i] = ST_IDLE;
        hold_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (o_rise[i]) begin
              state_d[i] = ST_PRESSED;
              hold_d[i]  = '0;
            end
          end
          ST_PRESSED: begin
            if (tick) begin
              if (hold_q[i] == 32'(LONG_TICKS - 1)) begin
                long_d[i]  = 1'b1;
                hold_d[i]  = '0;
                state_d[i] = ST_HELD;
              end else begin
                hold_d[i] = hold_q[i] + 32'd1;
              end
            end
          end
          ST_HELD: begin
`ifdef BTN_AUTOREPEAT_EN
            if (tick) begin
              if (hold_q[i] == 32'(REPEAT_TICKS - 1)) begin
                rpt_d[i]  = 1'b1;
                hold_d[i] = '0;
              end else begin
                hold_d[i] = hold_q[i] + 32'd1;
              end
            end
`endif
          end
          default: begin
            state_d[i] = ST_IDLE;
            hold_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // Long-press FSM state, hold counter and registered event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        hold_q[i]  <= '0;
      end
      o_long <= '0;
`ifdef BTN_AUTOREPEAT_EN
      o_rpt  <= '0;
`endif
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
      end
      o_long <= long_d;
`ifdef BTN_AUTOREPEAT_EN
      o_rpt  <= rpt_d;
`endif
    end
  end

`ifndef BTN_AUTOREPEAT_EN
  assign o_rpt = '0;
`endif

endmodule
